// File: rtl/dc_ipu_scale_sequencer.sv
// IPU scaler sampling sequencer: walks output pixels in raster order and
// emits source coordinates plus filter coefficients per pixel.
module dc_ipu_scale_sequencer #(
  parameter int COEFF_WIDTH   = 8,
  parameter int POS_INT_WIDTH = 12,
  parameter int FRACT_WIDTH   = 16
) (
  input  logic                                 clk,
  input  logic                                 nreset,
  input  logic                                 clr,
  input  logic                                 start,
  input  logic [POS_INT_WIDTH-1:0]             cfg_out_width,
  input  logic [POS_INT_WIDTH-1:0]             cfg_out_height,
  input  logic [POS_INT_WIDTH+FRACT_WIDTH-1:0] cfg_step_x,
  input  logic [POS_INT_WIDTH+FRACT_WIDTH-1:0] cfg_step_y,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [POS_INT_WIDTH-1:0]             out_src_x,
  output logic [POS_INT_WIDTH-1:0]             out_src_y,
  output logic [COEFF_WIDTH-1:0]               out_coeff_x,
  output logic [COEFF_WIDTH-1:0]               out_coeff_y,
  output logic                                 out_last_x,
  output logic                                 out_last_y
);

  localparam int AW = POS_INT_WIDTH + FRACT_WIDTH;
  localparam logic [POS_INT_WIDTH-1:0] CNT_ONE = POS_INT_WIDTH'(1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t                   state;
  logic [AW-1:0]            acc_x;
  logic [AW-1:0]            acc_y;
  logic [AW-1:0]            step_x_q;
  logic [AW-1:0]            step_y_q;
  logic [POS_INT_WIDTH-1:0] x_cnt;
  logic [POS_INT_WIDTH-1:0] y_cnt;
  logic [POS_INT_WIDTH-1:0] width_q;
  logic [POS_INT_WIDTH-1:0] height_q;

  logic xfer;
  logic at_last_x;
  logic at_last_y;
  logic dims_ok;

  assign xfer      = out_valid && out_ready;
  assign at_last_x = (x_cnt == width_q - CNT_ONE);
  assign at_last_y = (y_cnt == height_q - CNT_ONE);
  assign dims_ok   = (cfg_out_width != '0) && (cfg_out_height != '0);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      acc_x     <= '0;
      acc_y     <= '0;
      x_cnt     <= '0;
      y_cnt     <= '0;
      width_q   <= '0;
      height_q  <= '0;
      step_x_q  <= '0;
      step_y_q  <= '0;
    end else begin
      done <= 1'b0;
      if (clr) begin
        state     <= IDLE;
        busy      <= 1'b0;
        out_valid <= 1'b0;
        acc_x     <= '0;
        acc_y     <= '0;
        x_cnt     <= '0;
        y_cnt     <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start && dims_ok) begin
              width_q   <= cfg_out_width;
              height_q  <= cfg_out_height;
              step_x_q  <= cfg_step_x;
              step_y_q  <= cfg_step_y;
              acc_x     <= '0;
              acc_y     <= '0;
              x_cnt     <= '0;
              y_cnt     <= '0;
              state     <= RUN;
              busy      <= 1'b1;
              out_valid <= 1'b1;
            end else if (start) begin
              done <= 1'b1;
            end
          end
          RUN: begin
            if (xfer) begin
              if (!at_last_x) begin
                x_cnt <= x_cnt + CNT_ONE;
                acc_x <= acc_x + step_x_q;
              end else if (!at_last_y) begin
                x_cnt <= '0;
                acc_x <= '0;
                y_cnt <= y_cnt + CNT_ONE;
                acc_y <= acc_y + step_y_q;
              end else begin
                // Clear position so the idle outputs read back as zero
                state     <= IDLE;
                busy      <= 1'b0;
                out_valid <= 1'b0;
                done      <= 1'b1;
                acc_x     <= '0;
                acc_y     <= '0;
                x_cnt     <= '0;
                y_cnt     <= '0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign out_src_x   = acc_x[AW-1 -: POS_INT_WIDTH];
  assign out_src_y   = acc_y[AW-1 -: POS_INT_WIDTH];
  assign out_coeff_x = acc_x[FRACT_WIDTH-1 -: COEFF_WIDTH];
  assign out_coeff_y = acc_y[FRACT_WIDTH-1 -: COEFF_WIDTH];
  assign out_last_x  = out_valid && at_last_x;
  assign out_last_y  = out_valid && at_last_y;

endmodule

// File: tb/tb_dc_ipu_scale_sequencer.sv
// Self-checking bench for dc_ipu_scale_sequencer: directed tables,
// hand-written corner sequences and randomized runs against a raster model.
module tb_dc_ipu_scale_sequencer;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic [11:0] cfg_out_width = '0;
  logic [11:0] cfg_out_height = '0;
  logic [27:0] cfg_step_x = '0;
  logic [27:0] cfg_step_y = '0;
  logic        busy;
  logic        done;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] out_src_x;
  logic [11:0] out_src_y;
  logic [7:0]  out_coeff_x;
  logic [7:0]  out_coeff_y;
  logic        out_last_x;
  logic        out_last_y;

  int checks = 0;
  int errors = 0;
  logic [41:0] cap[$];

  typedef struct {
    logic [11:0] sx;
    logic [7:0]  cx;
    logic [11:0] sy;
    logic [7:0]  cy;
    logic        lx;
    logic        ly;
  } vec_t;

  vec_t tab1[4];
  vec_t tab2[6];

  dc_ipu_scale_sequencer #(
    .COEFF_WIDTH(8),
    .POS_INT_WIDTH(12),
    .FRACT_WIDTH(16)
  ) dut (
    .clk(clk),
    .nreset(nreset),
    .clr(clr),
    .start(start),
    .cfg_out_width(cfg_out_width),
    .cfg_out_height(cfg_out_height),
    .cfg_step_x(cfg_step_x),
    .cfg_step_y(cfg_step_y),
    .busy(busy),
    .done(done),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_src_x(out_src_x),
    .out_src_y(out_src_y),
    .out_coeff_x(out_coeff_x),
    .out_coeff_y(out_coeff_y),
    .out_last_x(out_last_x),
    .out_last_y(out_last_y)
  );

  always #5 clk = ~clk;

  function automatic logic [41:0] pk(vec_t v);
    return {v.sx, v.cx, v.sy, v.cy, v.lx, v.ly};
  endfunction

  function automatic logic [41:0] dut_beat();
    return {out_src_x, out_coeff_x, out_src_y, out_coeff_y,
            out_last_x, out_last_y};
  endfunction

  // Beat k of a w x h frame sits at pixel (k%w, k/w); position = index*step
  function automatic logic [41:0] model(int k, int w, int h,
                                        logic [27:0] sx, logic [27:0] sy);
    int x = k % w;
    int y = k / w;
    logic [27:0] ax = 28'(longint'(x) * longint'(sx));
    logic [27:0] ay = 28'(longint'(y) * longint'(sy));
    vec_t v;
    v.sx = ax[27:16];
    v.cx = ax[15:8];
    v.sy = ay[27:16];
    v.cy = ay[15:8];
    v.lx = (x == w - 1);
    v.ly = (y == h - 1);
    return pk(v);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_seq(input int w, input int h, input logic [27:0] sx,
                         input logic [27:0] sy, input bit stall,
                         input bit midstart);
    int nb = 0;
    int nd = 0;
    int last_cyc = -1;
    int done_cyc = -1;
    int stretch = 0;
    bit ms_done = 0;
    bit prev_stall = 0;
    logic [41:0] prev = '0;
    cap.delete();
    @(negedge clk);
    cfg_out_width = 12'(w);
    cfg_out_height = 12'(h);
    cfg_step_x = sx;
    cfg_step_y = sy;
    start = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == 0) begin
        chk("first_valid", 64'(out_valid), 64'(1));
        chk("busy_run", 64'(busy), 64'(1));
        if (stall) begin
          cfg_out_width = 12'($urandom);
          cfg_out_height = 12'($urandom);
          cfg_step_x = 28'($urandom);
          cfg_step_y = 28'($urandom);
        end
      end
      if (midstart && !ms_done && nb == 2) begin
        start = 1'b1;
        ms_done = 1;
      end
      if (!stall) out_ready = 1'b1;
      else if (stretch > 0) begin
        stretch--;
        out_ready = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        stretch = $urandom_range(1, 8);
        out_ready = 1'b0;
      end else out_ready = 1'b1;
      if (prev_stall) begin
        chk("stall_valid", 64'(out_valid), 64'(1));
        chk("stall_hold", 64'(dut_beat()), 64'(prev));
      end
      if (done) begin
        nd++;
        done_cyc = cyc;
        chk("done_idle", 64'({busy, out_valid}), 64'(0));
      end
      if (out_valid && out_ready) begin
        chk($sformatf("beat%0d", nb), 64'(dut_beat()),
            64'(model(nb, w, h, sx, sy)));
        cap.push_back(dut_beat());
        nb++;
        last_cyc = cyc;
      end
      prev_stall = out_valid && !out_ready;
      prev = dut_beat();
      if (nd > 0 && cyc >= done_cyc + 2) break;
    end
    out_ready = 1'b0;
    start = 1'b0;
    chk("beat_count", 64'(nb), 64'(w * h));
    chk("done_count", 64'(nd), 64'(1));
    chk("done_timing", 64'(done_cyc), 64'(last_cyc + 1));
  endtask

  initial begin
    int nb;
    tab1[0] = '{12'd0, 8'h00, 12'd0, 8'h00, 1'b0, 1'b1};
    tab1[1] = '{12'd1, 8'h80, 12'd0, 8'h00, 1'b0, 1'b1};
    tab1[2] = '{12'd3, 8'h00, 12'd0, 8'h00, 1'b0, 1'b1};
    tab1[3] = '{12'd4, 8'h80, 12'd0, 8'h00, 1'b1, 1'b1};
    tab2[0] = '{12'd0, 8'h00, 12'd0, 8'h00, 1'b0, 1'b0};
    tab2[1] = '{12'd1, 8'h00, 12'd0, 8'h00, 1'b1, 1'b0};
    tab2[2] = '{12'd0, 8'h00, 12'd0, 8'h80, 1'b0, 1'b0};
    tab2[3] = '{12'd1, 8'h00, 12'd0, 8'h80, 1'b1, 1'b0};
    tab2[4] = '{12'd0, 8'h00, 12'd1, 8'h00, 1'b0, 1'b1};
    tab2[5] = '{12'd1, 8'h00, 12'd1, 8'h00, 1'b1, 1'b1};

    repeat (2) @(negedge clk);
    chk("reset_outs", 64'({dut_beat(), out_valid, busy, done}), 64'(0));
    nreset = 1'b1;
    @(negedge clk);
    chk("idle_outs", 64'({dut_beat(), out_valid, busy, done}), 64'(0));

    run_seq(4, 1, 28'h18000, 28'h10000, 0, 0);
    for (int i = 0; i < 4; i++)
      chk($sformatf("s1_tab%0d", i), 64'(cap[i]), 64'(pk(tab1[i])));

    run_seq(2, 3, 28'h10000, 28'h08000, 0, 0);
    for (int i = 0; i < 6; i++)
      chk($sformatf("s2_tab%0d", i), 64'(cap[i]), 64'(pk(tab2[i])));

    run_seq(2, 3, 28'h10000, 28'h08000, 1, 0);
    for (int i = 0; i < 6; i++)
      chk($sformatf("s3_tab%0d", i), 64'(cap[i]), 64'(pk(tab2[i])));

    run_seq(2, 3, 28'h10000, 28'h08000, 0, 1);

    // Zero-sized frame
    @(negedge clk);
    cfg_out_width = 12'd0;
    cfg_out_height = 12'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("zero_done", 64'({done, busy, out_valid}), 64'(3'b100));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("zero_quiet", 64'({done, busy, out_valid}), 64'(0));
    end

    // Abort with clr after three beats, then replay
    cfg_out_width = 12'd8;
    cfg_out_height = 12'd1;
    cfg_step_x = 28'h10000;
    cfg_step_y = 28'h10000;
    out_ready = 1'b1;
    start = 1'b1;
    nb = 0;
    for (int i = 0; i < 50 && nb < 3; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid && out_ready) nb++;
    end
    chk("clr_pre_beats", 64'(nb), 64'(3));
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    out_ready = 1'b0;
    chk("clr_idle", 64'({out_valid, busy, done}), 64'(0));
    chk("clr_pos", 64'(dut_beat()), 64'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("clr_no_done", 64'({done, out_valid}), 64'(0));
    end
    run_seq(8, 1, 28'h10000, 28'h10000, 0, 0);

    // Accumulator wrap near full scale
    run_seq(3, 1, 28'hFFFFFFF, 28'h10000, 0, 0);
    chk("wrap0", 64'(cap[0][41:22]), 64'(20'h00000));
    chk("wrap1", 64'(cap[1][41:22]), 64'(20'hFFFFF));
    chk("wrap2", 64'(cap[2][41:22]), 64'(20'hFFFFF));

    // Asynchronous reset mid-sequence
    @(negedge clk);
    cfg_out_width = 12'd3;
    cfg_out_height = 12'd2;
    cfg_step_x = 28'hFFFFFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    nreset = 1'b0;
    #1;
    chk("async_reset", 64'({dut_beat(), out_valid, busy, done}), 64'(0));
    @(negedge clk);
    nreset = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_no_done", 64'({done, out_valid, busy}), 64'(0));
    end

    for (int t = 0; t < 8; t++)
      run_seq($urandom_range(1, 5), $urandom_range(1, 4), 28'($urandom),
              28'($urandom), 1'(t % 2), 1'(t == 3));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dc_ipu_scale_sequencer.md
Name: dc_ipu_scale_sequencer

Overview:
Generates the per-output-pixel sampling sequence for the IPU scaler filter stage. For each output pixel in raster order, it steps fixed-point source-position accumulators in X and Y. Each step presents one transaction on a valid/ready interface: integer source coordinates (for texel-matrix fetch) and fractional coefficients (coeff_x/coeff_y for the nearest/bilinear/bicubic filters). One sequence covers one frame and is launched by a start pulse.

Parameters:
COEFF_WIDTH, 8, width of out_coeff_x/out_coeff_y; must be <= FRACT_WIDTH
POS_INT_WIDTH, 12, integer bits of source position and width of dimension counters
FRACT_WIDTH, 16, fractional bits of step and accumulators

Ports:
clk  in  1  clock
nreset  in  1  asynchronous active-low reset
clr  in  1  synchronous clear, aborts sequence
start  in  1  single-cycle launch pulse
cfg_out_width  in  POS_INT_WIDTH  output pixels per line
cfg_out_height  in  POS_INT_WIDTH  output lines per frame
cfg_step_x  in  POS_INT_WIDTH+FRACT_WIDTH  unsigned source increment per output pixel
cfg_step_y  in  POS_INT_WIDTH+FRACT_WIDTH  unsigned source increment per output line
busy  out  1  sequence in progress
done  out  1  one-cycle pulse at sequence end
out_valid  out  1  transaction valid
out_ready  in  1  downstream (filter) ready
out_src_x  out  POS_INT_WIDTH  acc_x integer part
out_src_y  out  POS_INT_WIDTH  acc_y integer part
out_coeff_x  out  COEFF_WIDTH  acc_x[FRACT_WIDTH-1 -: COEFF_WIDTH]
out_coeff_y  out  COEFF_WIDTH  acc_y[FRACT_WIDTH-1 -: COEFF_WIDTH]
out_last_x  out  1  last pixel of line
out_last_y  out  1  last line of frame

Behaviour:
- Reset (nreset low, async): state IDLE; all outputs 0; accumulators, counters and latched config 0.
- FSM states: IDLE and RUN.
- IDLE, start=1, both dimensions nonzero:
  - Latch all cfg_* inputs.
  - acc_x=acc_y=0, x_cnt=y_cnt=0.
  - Go to RUN next cycle.
  - First out_valid=1 one cycle after the start cycle.
- IDLE, start=1, either dimension 0: stay IDLE, busy stays 0, no transactions, done=1 the next cycle.
- RUN: busy=1, out_valid=1.
  - Transfer occurs when out_valid && out_ready.
  - Without a transfer, all out_* are held stable.
- On transfer, when x_cnt != width-1:
  - x_cnt++.
  - acc_x += step_x, wrapping modulo 2^(POS_INT_WIDTH+FRACT_WIDTH).
- On transfer, when x_cnt == width-1 and y_cnt != height-1:
  - x_cnt=0, acc_x=0.
  - y_cnt++, acc_y += step_y (wrapping).
- On transfer, when x_cnt == width-1 and y_cnt == height-1:
  - Go to IDLE; out_valid=0 and busy=0 next cycle.
  - done=1 for exactly that one cycle.
- out_last_x = (x_cnt == width-1); out_last_y = (y_cnt == height-1). Both are qualified by out_valid and are 0 in IDLE.
- Outputs come from registered state; there is no combinational path from out_ready to out_valid or out_* data.
- start during RUN is ignored. cfg_* changes during RUN are ignored.
- clr=1 in any state:
  - Next cycle: IDLE, out_valid=0, busy=0, done=0, counters and accumulators 0.
  - clr has priority over start and over a same-cycle transfer; that transfer is counted by downstream but the sequence is abandoned.
- Reset mid-RUN: immediate IDLE with outputs 0. No done pulse is produced.
- Transaction count per sequence is exactly width*height.
- Throughput: one transaction per cycle while out_ready=1.
- Coefficient MSB (acc_x[FRACT_WIDTH-1]) is the nearest-filter rounding bit: it is 1 when the fractional part is >= 0.5.

Test Plan:
- Defaults; width=4, height=1, step_x=0x18000 (1.5), step_y=0x10000, out_ready=1 -> 4 transactions: (src_x,coeff_x) = (0,0x00),(1,0x80),(3,0x00),(4,0x80); out_last_x only on the 4th; done one cycle after the 4th transfer; out_valid first seen one cycle after start.
- width=2, height=3, step_x=0x10000, step_y=0x8000 -> 6 transactions; (src_y,coeff_y) per line = (0,0x00),(0,0x80),(1,0x00); src_x resets to 0 each line; out_last_y only on the final two beats.
- Same config as scenario 2, out_ready toggled randomly with long low stretches -> out_* stable while stalled, no beats dropped or duplicated, exactly 6 beats, single done.
- width=0, height=5 start -> out_valid never asserts, busy stays 0, done pulses once next cycle. Start asserted during RUN -> ignored, sequence length unchanged.
- clr asserted after 3 of 8 beats -> out_valid=0 and busy=0 next cycle, no done. A following start replays from src_x=0, coeff_x=0.
- step_x=0xFFFFFFF (near max), width=3 -> acc_x wraps modulo 2^28; src_x = 0, 0xFFF, 0xFFF with coeff_x = 0x00, 0xFF, 0xFF. nreset pulsed mid-sequence -> all outputs 0 immediately.
